// File: rtl/eip_seq_pkg.sv
// Shared types and constants for the EIP sequencer: FSM state encoding and
// the EIP register command codes.
package eip_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4,
        ST_FAULT  = 3'd5
    } eip_state_e;

    localparam logic [3:0] EIP_WRITE = 4'h3;
    localparam logic [3:0] EIP_HOLD  = 4'h0;

endpackage

// File: rtl/eip_next_calc.sv
// Combinational next-EIP computation: fall-through, relative or absolute
// branch. All arithmetic wraps silently modulo 2^32.
module eip_next_calc (
    input  logic [31:0] eip,
    input  logic [2:0]  exec_len,
    input  logic        exec_jmp,
    input  logic        exec_abs,
    input  logic [31:0] exec_target,
    output logic [31:0] next_eip
);

    logic [31:0] fall_through;

    assign fall_through = eip + {29'd0, exec_len};

    always_comb begin
        next_eip = fall_through;
        if (exec_jmp) begin
            if (exec_abs) next_eip = exec_target;
            else          next_eip = fall_through + exec_target;
        end
    end

endmodule

// File: rtl/eip_sequencer.sv
// Instruction sequencer: drives the external EIP register, fetches the
// instruction at EIP, hands it to execute and applies the resulting next EIP.
module eip_sequencer
    import eip_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
    input  logic        clock_5,
    input  logic        reset,
    input  logic [31:0] eip,
    output logic [3:0]  eip_rw,
    output logic [31:0] eip_wdata,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [2:0]  exec_len,
    input  logic        exec_jmp,
    input  logic        exec_abs,
    input  logic [31:0] exec_target,
    input  logic        exec_halt,
    input  logic        resume,
    output logic        halted,
    output logic        fault
);

    eip_state_e  state;
    logic [7:0]  fetch_cnt;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic [31:0] next_eip_q;
    logic [31:0] calc_eip;
    logic        halt_pend;

    eip_next_calc u_next_calc (
        .eip         (eip),
        .exec_len    (exec_len),
        .exec_jmp    (exec_jmp),
        .exec_abs    (exec_abs),
        .exec_target (exec_target),
        .next_eip    (calc_eip)
    );

    always_ff @(posedge clock_5) begin
        if (reset) begin
            state         <= ST_INIT;
            fetch_cnt     <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            next_eip_q    <= '0;
            halt_pend     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: state <= ST_FETCH;
                ST_FETCH: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (fetch_ack) begin
                        instr_q       <= fetch_data;
                        instr_valid_q <= 1'b1;
                        fetch_cnt     <= '0;
                        state         <= ST_EXEC;
                    end else if (fetch_cnt == FETCH_TIMEOUT - 8'd1) begin
                        fetch_cnt <= '0;
                        state     <= ST_FAULT;
                    end else begin
                        fetch_cnt <= fetch_cnt + 8'd1;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        instr_valid_q <= 1'b0;
                        if (exec_len == 3'd0) begin
                            state <= ST_FAULT;
                        end else begin
                            next_eip_q <= calc_eip;
                            halt_pend  <= exec_halt;
                            state      <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: state <= halt_pend ? ST_HALT : ST_FETCH;
                ST_HALT:   if (resume) state <= ST_FETCH;
                ST_FAULT:  state <= ST_FAULT;
                default:   state <= ST_FAULT;
            endcase
        end
    end

    // Outputs are forced to zero combinationally while reset is held.
    always_comb begin
        eip_rw     = EIP_HOLD;
        eip_wdata  = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        halted     = 1'b0;
        fault      = 1'b0;
        if (!reset) begin
            case (state)
                ST_INIT: begin
                    eip_rw    = EIP_WRITE;
                    eip_wdata = RESET_VECTOR;
                end
                ST_FETCH: begin
                    fetch_req  = 1'b1;
                    fetch_addr = eip;
                end
                ST_UPDATE: begin
                    eip_rw    = EIP_WRITE;
                    eip_wdata = next_eip_q;
                end
                ST_HALT:  halted = 1'b1;
                ST_FAULT: fault  = 1'b1;
                default: ;
            endcase
        end
    end

    assign instr       = reset ? 32'd0 : instr_q;
    assign instr_valid = reset ? 1'b0  : instr_valid_q;

endmodule

// File: tb/tb_eip_sequencer.sv
// Directed bench for eip_sequencer; the bench also models the external EIP
// register, which loads eip_wdata whenever eip_rw commands a write.
module tb_eip_sequencer;
    import eip_seq_pkg::*;

    logic        clock_5 = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] eip_q = 32'd0;
    logic [3:0]  eip_rw;
    logic [31:0] eip_wdata;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack = 1'b0;
    logic [31:0] fetch_data = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic [2:0]  exec_len = 3'd0;
    logic        exec_jmp = 1'b0;
    logic        exec_abs = 1'b0;
    logic [31:0] exec_target = 32'd0;
    logic        exec_halt = 1'b0;
    logic        resume = 1'b0;
    logic        halted;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clock_5 = ~clock_5;

    always @(posedge clock_5) if (eip_rw == EIP_WRITE) eip_q <= eip_wdata;

    eip_sequencer #(.RESET_VECTOR(32'h100), .FETCH_TIMEOUT(8'd255)) dut (
        .clock_5     (clock_5),
        .reset       (reset),
        .eip         (eip_q),
        .eip_rw      (eip_rw),
        .eip_wdata   (eip_wdata),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .fetch_data  (fetch_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .exec_len    (exec_len),
        .exec_jmp    (exec_jmp),
        .exec_abs    (exec_abs),
        .exec_target (exec_target),
        .exec_halt   (exec_halt),
        .resume      (resume),
        .halted      (halted),
        .fault       (fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rw"}, eip_rw, 32'h0);
        chk({tag, "_wdata"}, eip_wdata, 32'h0);
        chk({tag, "_req"}, fetch_req, 32'h0);
        chk({tag, "_addr"}, fetch_addr, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_valid"}, instr_valid, 32'h0);
        chk({tag, "_halted"}, halted, 32'h0);
        chk({tag, "_fault"}, fault, 32'h0);
    endtask

    // Entered at a negedge while in FETCH; leaves at the negedge after UPDATE.
    task automatic run_instr(input logic [31:0] fetch_at, input logic [31:0] data,
                             input logic [2:0] len, input logic jmp, input logic abs_b,
                             input logic [31:0] tgt, input logic hlt,
                             input logic [31:0] exp_next);
        chk("fetch_req", fetch_req, 32'h1);
        chk("fetch_addr", fetch_addr, fetch_at);
        fetch_ack = 1'b1; fetch_data = data;
        @(negedge clock_5);
        fetch_ack = 1'b0; fetch_data = 32'd0;
        chk("instr", instr, data);
        chk("instr_valid", instr_valid, 32'h1);
        chk("exec_no_req", fetch_req, 32'h0);
        exec_done = 1'b1; exec_len = len; exec_jmp = jmp; exec_abs = abs_b;
        exec_target = tgt; exec_halt = hlt;
        @(negedge clock_5);
        exec_done = 1'b0; exec_len = 3'd0; exec_jmp = 1'b0; exec_abs = 1'b0;
        exec_target = 32'd0; exec_halt = 1'b0;
        chk("upd_rw", eip_rw, 32'h3);
        chk("upd_wdata", eip_wdata, exp_next);
        chk("upd_valid_clr", instr_valid, 32'h0);
        @(negedge clock_5);
    endtask

    initial begin
        repeat (3) @(negedge clock_5);
        chk_reset_outs("rst");

        @(posedge clock_5); #1 reset = 1'b0;
        @(negedge clock_5);
        chk("init_rw", eip_rw, 32'h3);
        chk("init_wdata", eip_wdata, 32'h100);
        chk("init_req", fetch_req, 32'h0);
        @(negedge clock_5);
        chk("first_rw", eip_rw, 32'h0);

        run_instr(32'h100, 32'hDEADBEEF, 3'd3, 1'b0, 1'b0, 32'd0, 1'b0, 32'h103);
        run_instr(32'h103, 32'h11111111, 3'd1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200);
        run_instr(32'h200, 32'h22222222, 3'd2, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b0, 32'h1F2);
        run_instr(32'h1F2, 32'h33333333, 3'd5, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE);
        run_instr(32'hFFFF_FFFE, 32'h44444444, 3'd4, 1'b0, 1'b0, 32'd0, 1'b0, 32'h2);
        run_instr(32'h2, 32'h55555555, 3'd7, 1'b1, 1'b1, 32'h4000, 1'b1, 32'h4000);

        chk("halt_flag", halted, 32'h1);
        chk("halt_no_req", fetch_req, 32'h0);
        chk("halt_rw", eip_rw, 32'h0);
        // A stray exec_done with len 0 in HALT must not fault.
        exec_done = 1'b1; exec_len = 3'd0; exec_halt = 1'b1;
        @(negedge clock_5);
        exec_done = 1'b0; exec_halt = 1'b0;
        chk("halt_hold", halted, 32'h1);
        chk("halt_nofault", fault, 32'h0);
        resume = 1'b1;
        @(negedge clock_5);
        resume = 1'b0;
        chk("resume_halted", halted, 32'h0);
        chk("resume_req", fetch_req, 32'h1);
        chk("resume_addr", fetch_addr, 32'h4000);

        fetch_ack = 1'b1; fetch_data = 32'h12345678;
        @(negedge clock_5);
        fetch_ack = 1'b0;
        exec_done = 1'b1; exec_len = 3'd0;
        @(negedge clock_5);
        exec_done = 1'b0;
        chk("len0_fault", fault, 32'h1);
        chk("len0_rw", eip_rw, 32'h0);
        chk("len0_req", fetch_req, 32'h0);
        resume = 1'b1;
        repeat (3) @(negedge clock_5);
        resume = 1'b0;
        chk("fault_hold", fault, 32'h1);
        chk("fault_eip", eip_q, 32'h4000);

        reset = 1'b1;
        @(negedge clock_5);
        chk_reset_outs("rst2");
        @(posedge clock_5); #1 reset = 1'b0;
        @(negedge clock_5);
        chk("init2_rw", eip_rw, 32'h3);
        @(negedge clock_5);
        repeat (5) @(negedge clock_5);
        chk("midfetch_req", fetch_req, 32'h1);
        reset = 1'b1;
        @(negedge clock_5);
        chk("rst_fetch_req", fetch_req, 32'h0);
        @(posedge clock_5); #1 reset = 1'b0;
        @(negedge clock_5);
        chk("rst_fetch_init", eip_rw, 32'h3);
        chk("rst_fetch_wdata", eip_wdata, 32'h100);
        @(negedge clock_5);
        chk("to_addr", fetch_addr, 32'h100);

        // Now in FETCH cycle 1; the 255th FETCH cycle is the last one.
        repeat (254) @(negedge clock_5);
        chk("to_last_req", fetch_req, 32'h1);
        chk("to_last_fault", fault, 32'h0);
        @(negedge clock_5);
        chk("to_fault", fault, 32'h1);
        chk("to_req", fetch_req, 32'h0);
        chk("to_addr0", fetch_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
